// File: rtl/spi_shifter.sv
// SPI master byte shifter: 16 half-period transfer, MSB first, with
// programmable SCK divider, clock polarity and two active-low selects.
//
// Ports:
//   CLK      system clock, all state on its rising edge
//   RST      synchronous active-high reset
//   CTRL_WE  one-cycle write strobe
//   CTRL_A   0 = data/start register, 1 = config register
//   CTRL_D   write data; config = {DIV, -, CPOL, nSS}
//   MISO     serial in from device 0, device 1, expansion port
//   MOSI     serial data out, MSB first
//   SCK      serial clock, idles at CPOL
//   nSS      active-low device selects
//   RDATA    last received byte
//   BUSY     transfer in progress
//   DONE     high in the final cycle of a transfer
module spi_shifter #(
  parameter int DIVW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CTRL_WE,
  input  logic            CTRL_A,
  input  logic [7:0]      CTRL_D,
  input  logic [2:0]      MISO,
  output logic            MOSI,
  output logic            SCK,
  output logic [1:0]      nSS,
  output logic [7:0]      RDATA,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] dcnt_q;
  logic [3:0]      hcnt_q;
  logic            cpol_q;
  logic            sck_q;
  logic            mosi_q;
  logic [1:0]      nss_q;
  logic [6:0]      tx_q;
  logic [7:0]      rx_q;
  logic [7:0]      rdata_q;

  logic busy;
  logic wr_data;
  logic wr_cfg;
  logic hp_end;
  logic rise_end;
  logic fall_end;
  logic last_end;
  logic miso_sel;
  logic done;

  assign busy    = (state_q == SHIFT);
  assign wr_data = CTRL_WE & ~CTRL_A & ~busy;
  assign wr_cfg  = CTRL_WE &  CTRL_A & ~busy;

  // Divider expiry marks the end of the current half-period.
  assign hp_end   = busy & (dcnt_q == '0);
  // hcnt is 0-based, so an even count ends an odd half-period.
  assign rise_end = hp_end & ~hcnt_q[0];
  assign fall_end = hp_end &  hcnt_q[0] & (hcnt_q != 4'd15);
  assign last_end = hp_end & (hcnt_q == 4'd15);

  // Expansion port answers only when neither device is selected.
  assign miso_sel = (MISO[0] & ~nss_q[0])
                  | (MISO[1] & ~nss_q[1])
                  | (MISO[2] &  nss_q[0] & nss_q[1]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DONE sits in the last busy cycle, so a write there is still blocked.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_data) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_end) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= '0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      cpol_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      nss_q   <= 2'b11;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      // SCK follows CPOL immediately so the idle level is always right.
      if (wr_cfg) begin
        nss_q  <= CTRL_D[1:0];
        cpol_q <= CTRL_D[2];
        sck_q  <= CTRL_D[2];
        div_q  <= CTRL_D[7 -: DIVW];
      end
      if (wr_data) begin
        mosi_q <= CTRL_D[7];
        tx_q   <= CTRL_D[6:0];
        dcnt_q <= div_q;
        hcnt_q <= '0;
        rx_q   <= '0;
      end
      if (busy) begin
        if (hp_end) begin
          dcnt_q <= div_q;
          hcnt_q <= hcnt_q + 4'd1;
        end else begin
          dcnt_q <= dcnt_q - 1'b1;
        end
        unique case (1'b1)
          rise_end: begin
            sck_q <= ~cpol_q;
            rx_q  <= {rx_q[6:0], miso_sel};
          end
          fall_end: begin
            sck_q  <= cpol_q;
            mosi_q <= tx_q[6];
            tx_q   <= {tx_q[5:0], 1'b0};
          end
          last_end: begin
            sck_q   <= cpol_q;
            rdata_q <= rx_q;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign MOSI  = mosi_q;
  assign SCK   = sck_q;
  assign nSS   = nss_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy;
  assign DONE  = done;

endmodule

// File: tb/tb_spi_shifter.sv
// Randomized bench for spi_shifter against a transfer-level model.
// Expected waveforms are derived from cycle index arithmetic.
module tb_spi_shifter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CTRL_WE;
  logic       CTRL_A;
  logic [7:0] CTRL_D;
  logic [2:0] MISO;
  logic       MOSI;
  logic       SCK;
  logic [1:0] nSS;
  logic [7:0] RDATA;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_nss;
  logic       m_cpol;
  int         m_div;
  logic [7:0] m_rdata;
  logic       m_mosi;

  spi_shifter #(.DIVW(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CTRL_WE (CTRL_WE),
    .CTRL_A  (CTRL_A),
    .CTRL_D  (CTRL_D),
    .MISO    (MISO),
    .MOSI    (MOSI),
    .SCK     (SCK),
    .nSS     (nSS),
    .RDATA   (RDATA),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic mreset;
    m_nss   = 2'b11;
    m_cpol  = 1'b0;
    m_div   = 0;
    m_rdata = 8'h00;
    m_mosi  = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_sck"}, SCK, m_cpol);
    chk({tag, "_nss"}, nSS, m_nss);
    chk({tag, "_rdata"}, RDATA, m_rdata);
    chk({tag, "_mosi"}, MOSI, m_mosi);
  endtask

  function automatic logic sel(input logic [2:0] m, input logic [1:0] n);
    return (m[0] & ~n[0]) | (m[1] & ~n[1]) | (m[2] & n[0] & n[1]);
  endfunction

  // Put the pattern bit on every line that the selects enable;
  // remaining lines carry random noise.
  function automatic logic [2:0] drive(input logic [1:0] n, input logic b);
    logic [2:0] v;
    v = 3'($urandom);
    if (!n[0]) v[0] = b;
    if (!n[1]) v[1] = b;
    if (n == 2'b11) v[2] = b;
    return v;
  endfunction

  task automatic cfg(input logic [7:0] d);
    CTRL_WE = 1'b1;
    CTRL_A  = 1'b1;
    CTRL_D  = d;
    tick;
    CTRL_WE = 1'b0;
    m_nss  = d[1:0];
    m_cpol = d[2];
    m_div  = int'(d[7:4]);
    idle_chk("cfg");
  endtask

  // mode 0 plain, 1 writes while busy, 2 reset at cycle 7,
  // 3 data write in the DONE cycle
  task automatic shift(input logic [7:0] d,
                       input logic [7:0] pat,
                       input int mode);
    int hl;
    int n;
    int h;
    logic [7:0] erx;
    hl  = m_div + 1;
    n   = 16 * hl;
    erx = 8'h00;
    CTRL_WE = 1'b1;
    CTRL_A  = 1'b0;
    CTRL_D  = d;
    tick;
    for (int c = 0; c < n; c++) begin
      CTRL_WE = 1'b0;
      h = c / hl;
      chk("busy", BUSY, 1);
      chk("done", DONE, (c == n - 1));
      chk("sck", SCK, m_cpol ^ h[0]);
      chk("mosi", MOSI, d[7 - h / 2]);
      chk("rdata_hold", RDATA, m_rdata);
      chk("nss_hold", nSS, m_nss);
      MISO = drive(m_nss, pat[7 - c / (2 * hl)]);
      if ((h % 2 == 0) && ((c + 1) % hl == 0))
        erx = {erx[6:0], sel(MISO, m_nss)};
      if (mode == 1 && c == 3) begin
        CTRL_WE = 1'b1;
        CTRL_A  = 1'b0;
        CTRL_D  = 8'h00;
      end
      if (mode == 1 && c == 5) begin
        CTRL_WE = 1'b1;
        CTRL_A  = 1'b1;
        CTRL_D  = 8'hFF;
      end
      if (mode == 2 && c == 7) begin
        RST = 1'b1;
        tick;
        RST = 1'b0;
        mreset;
        idle_chk("abort");
        return;
      end
      if (mode == 3 && c == n - 1) begin
        CTRL_WE = 1'b1;
        CTRL_A  = 1'b0;
        CTRL_D  = d;
      end
      tick;
    end
    CTRL_WE = 1'b0;
    m_rdata = erx;
    m_mosi  = d[0];
    idle_chk("end");
  endtask

  initial begin
    RST     = 1'b1;
    CTRL_WE = 1'b0;
    CTRL_A  = 1'b0;
    CTRL_D  = 8'h00;
    MISO    = 3'b000;
    mreset;
    tick;
    tick;
    idle_chk("reset");
    RST = 1'b0;
    tick;
    idle_chk("post_reset");

    cfg(8'h02);
    shift(8'hA5, 8'h3C, 0);
    chk("rx_3c", RDATA, 8'h3C);

    cfg(8'h36);
    shift(8'hFF, 8'($urandom), 0);

    cfg(8'h02);
    shift(8'h5A, 8'($urandom), 1);

    shift(8'hC3, 8'($urandom), 2);

    cfg(8'h03);
    shift(8'h6E, 8'h81, 0);
    chk("rx_81", RDATA, 8'h81);

    cfg(8'hF1);
    shift(8'h39, 8'($urandom), 0);

    cfg(8'h06);
    shift(8'h96, 8'($urandom), 3);
    shift(8'h96, 8'($urandom), 0);

    RST     = 1'b1;
    CTRL_WE = 1'b1;
    CTRL_A  = 1'b1;
    CTRL_D  = 8'hFF;
    tick;
    RST     = 1'b0;
    CTRL_WE = 1'b0;
    mreset;
    idle_chk("rst_prio");

    for (int i = 0; i < 6; i++) begin
      cfg(8'($urandom));
      shift(8'($urandom), 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
